tetris_coord_unit: RTL and testbench



---
 rtl/tetris_coord_unit.sv | 105 ++++++++++
 tb/tb_tetris_coord_unit.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/tetris_coord_unit.sv
// Tetris VGA helper: 13-bit LFSR piece selector, frame-address to (x,y) decoder,
// and piece reference pixel to playfield cell index. Define COORD_REG_EN to register coordinate outputs.
module tetris_coord_unit #(
  parameter logic [12:0] LFSR_SEED = 13'h0001,
  parameter int unsigned H_RES     = 640,
  parameter int unsigned FIELD_X0  = 240,
  parameter int unsigned CELL      = 16,
  parameter int unsigned COLS      = 10,
  parameter int unsigned ROWS      = 30
) (
  input  logic        iVGA_CLK,
  input  logic        rst,
  input  logic        lfsr_en,
  output logic [12:0] randomNum,
  input  logic [18:0] ADDR,
  output logic [9:0]  addr_x,
  output logic [9:0]  addr_y,
  input  logic [9:0]  ref_x,
  input  logic [9:0]  ref_y,
  output logic [8:0]  gridNum,
  output logic        grid_valid
);

  localparam logic [12:0] SEED_EFF = (LFSR_SEED == 13'h0000) ? 13'h0001 : LFSR_SEED;
  localparam int unsigned CSH      = $clog2(CELL);

  logic [12:0] lfsr;
  logic        fb;

  assign fb        = lfsr[12] ^ lfsr[11] ^ lfsr[10] ^ lfsr[7];
  assign randomNum = lfsr;

  // The all-zero state is a lock-up point, so it reloads the seed even when disabled.
  always_ff @(posedge iVGA_CLK or posedge rst) begin
    if (rst)                 lfsr <= SEED_EFF;
    else if (lfsr == '0)     lfsr <= SEED_EFF;
    else if (lfsr_en)        lfsr <= {lfsr[11:0], fb};
  end

  // Restoring subtract network: quotient bits 9..0 against H_RES shifted left.
  logic [19:0] div_rem;
  logic [19:0] div_sub;
  logic [9:0]  div_q;

  always_comb begin
    div_rem = {1'b0, ADDR};
    div_sub = '0;
    div_q   = '0;
    for (int unsigned k = 0; k < 10; k++) begin
      div_sub = 20'(H_RES) << (9 - k);
      if (div_rem >= div_sub) begin
        div_rem          = div_rem - div_sub;
        div_q[9 - k]     = 1'b1;
      end
    end
  end

  logic [9:0] ax_c;
  logic [9:0] ay_c;

  assign ax_c = div_rem[9:0];
  assign ay_c = div_q;

  logic [9:0] dx;
  logic [9:0] col;
  logic [9:0] row;
  logic [9:0] lin;
  logic       in_rng;
  logic [8:0] gn_c;

  always_comb begin
    dx     = ref_x - 10'(FIELD_X0);
    col    = dx >> CSH;
    row    = ref_y >> CSH;
    lin    = 10'(row * COLS) + col;
    in_rng = ({1'b0, ref_x} >= 11'(FIELD_X0)) &&
             ({1'b0, ref_x} <  11'(FIELD_X0 + COLS * CELL)) &&
             ({1'b0, ref_y} <  11'(ROWS * CELL));
    gn_c   = in_rng ? lin[8:0] : '1;
  end

`ifdef COORD_REG_EN
  always_ff @(posedge iVGA_CLK or posedge rst) begin
    if (rst) begin
      addr_x     <= '0;
      addr_y     <= '0;
      gridNum    <= '0;
      grid_valid <= 1'b0;
    end else begin
      addr_x     <= ax_c;
      addr_y     <= ay_c;
      gridNum    <= gn_c;
      grid_valid <= in_rng;
    end
  end
`else
  always_comb begin
    addr_x     = ax_c;
    addr_y     = ay_c;
    gridNum    = gn_c;
    grid_valid = in_rng;
  end
`endif

endmodule

// File: tb/tb_tetris_coord_unit.sv
// Directed bench for tetris_coord_unit: LFSR sequence/period plus decoder and grid-index scoreboard.
module tb_tetris_coord_unit;

  logic        iVGA_CLK = 1'b0;
  logic        rst;
  logic        lfsr_en;
  logic [12:0] randomNum;
  logic [18:0] ADDR;
  logic [9:0]  addr_x;
  logic [9:0]  addr_y;
  logic [9:0]  ref_x;
  logic [9:0]  ref_y;
  logic [8:0]  gridNum;
  logic        grid_valid;

  tetris_coord_unit dut (
    .iVGA_CLK   (iVGA_CLK),
    .rst        (rst),
    .lfsr_en    (lfsr_en),
    .randomNum  (randomNum),
    .ADDR       (ADDR),
    .addr_x     (addr_x),
    .addr_y     (addr_y),
    .ref_x      (ref_x),
    .ref_y      (ref_y),
    .gridNum    (gridNum),
    .grid_valid (grid_valid)
  );

  always #5 iVGA_CLK = ~iVGA_CLK;

  typedef struct packed {
    logic [9:0] ax;
    logic [9:0] ay;
    logic [8:0] gn;
    logic       gv;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [18:0] a, input logic [9:0] x, input logic [9:0] y, input exp_t e);
    exp_t g;
    @(negedge iVGA_CLK);
    ADDR  = a;
    ref_x = x;
    ref_y = y;
    sb.push_back(e);
`ifdef COORD_REG_EN
    @(posedge iVGA_CLK);
    #1;
`else
    #1;
`endif
    g = sb.pop_front();
    check($sformatf("addr_x[a=%0d]", a), 32'(addr_x), 32'(g.ax));
    check($sformatf("addr_y[a=%0d]", a), 32'(addr_y), 32'(g.ay));
    check($sformatf("gridNum[%0d,%0d]", x, y), 32'(gridNum), 32'(g.gn));
    check($sformatf("grid_valid[%0d,%0d]", x, y), 32'(grid_valid), 32'(g.gv));
  endtask

  initial begin
    int unsigned period;
    logic        saw_zero;

    rst = 1'b1; lfsr_en = 1'b0; ADDR = '0; ref_x = '0; ref_y = '0;
    #12;
    check("rst_randomNum", 32'(randomNum), 32'h0001);
`ifdef COORD_REG_EN
    check("rst_addr_x", 32'(addr_x), 32'd0);
    check("rst_gridNum", 32'(gridNum), 32'd0);
`endif
    // reset must win over a simultaneous enable
    lfsr_en = 1'b1;
    @(posedge iVGA_CLK); #1;
    check("rst_beats_en", 32'(randomNum), 32'h0001);

    @(negedge iVGA_CLK); rst = 1'b0;
    repeat (7) @(posedge iVGA_CLK);
    #1;
    check("lfsr_7", 32'(randomNum), 32'h0080);
    @(posedge iVGA_CLK); #1;
    check("lfsr_8", 32'(randomNum), 32'h0101);
    lfsr_en = 1'b0;
    repeat (3) @(posedge iVGA_CLK);
    #1;
    check("lfsr_hold", 32'(randomNum), 32'h0101);

    // full period from reset
    @(negedge iVGA_CLK); rst = 1'b1;
    @(negedge iVGA_CLK); rst = 1'b0; lfsr_en = 1'b1;
    period = 0; saw_zero = 1'b0;
    for (int unsigned c = 1; c <= 9000; c++) begin
      @(posedge iVGA_CLK); #1;
      if (randomNum == 13'h0000) saw_zero = 1'b1;
      if (randomNum == 13'h0001) begin
        period = c;
        break;
      end
    end
    lfsr_en = 1'b0;
    check("lfsr_no_zero", 32'(saw_zero), 32'd0);
    check("lfsr_period", period, 32'd8191);

    step(19'd0,      10'd240, 10'd0,   '{ax: 10'd0,   ay: 10'd0,   gn: 9'd0,     gv: 1'b1});
    step(19'd639,    10'd320, 10'd0,   '{ax: 10'd639, ay: 10'd0,   gn: 9'd5,     gv: 1'b1});
    step(19'd640,    10'd256, 10'd16,  '{ax: 10'd0,   ay: 10'd1,   gn: 9'd11,    gv: 1'b1});
    step(19'd307199, 10'd384, 10'd464, '{ax: 10'd639, ay: 10'd479, gn: 9'd299,   gv: 1'b1});
    step(19'd524287, 10'd250, 10'd20,  '{ax: 10'd127, ay: 10'd819, gn: 9'd10,    gv: 1'b1});
    step(19'd1000,   10'd239, 10'd0,   '{ax: 10'd360, ay: 10'd1,   gn: 9'h1FF,   gv: 1'b0});
    step(19'd100,    10'd400, 10'd0,   '{ax: 10'd100, ay: 10'd0,   gn: 9'h1FF,   gv: 1'b0});
    step(19'd307200, 10'd240, 10'd480, '{ax: 10'd0,   ay: 10'd480, gn: 9'h1FF,   gv: 1'b0});
    step(19'd640,    10'd399, 10'd479, '{ax: 10'd0,   ay: 10'd1,   gn: 9'd299,   gv: 1'b1});

`ifdef COORD_REG_EN
    // asynchronous clear between edges
    lfsr_en = 1'b1;
    @(posedge iVGA_CLK); @(posedge iVGA_CLK);
    #3;
    rst = 1'b1;
    #1;
    check("async_addr_x", 32'(addr_x), 32'd0);
    check("async_addr_y", 32'(addr_y), 32'd0);
    check("async_gridNum", 32'(gridNum), 32'd0);
    check("async_valid", 32'(grid_valid), 32'd0);
    check("async_random", 32'(randomNum), 32'h0001);
    lfsr_en = 1'b0;
    @(negedge iVGA_CLK); rst = 1'b0;
`endif

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
